// File: rtl/adsd_pkg.sv
// ----------------------------------------------------------------------------
// adsd_pkg
// Shared constants and types for the ADSD RISC memory arbiter.
//   ADDR_W      : default word address width
//   DATA_W      : default data word width
//   mem_owner_t : which port a pending memory read belongs to
// ----------------------------------------------------------------------------
package adsd_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } mem_owner_t;

endpackage : adsd_pkg

// File: rtl/adsd_mem_arbiter.sv
// ----------------------------------------------------------------------------
// adsd_mem_arbiter
// Shares one single-port synchronous 16-bit memory between the CPU
// instruction-fetch port and the load/store data port. At most one access
// is granted per cycle; read data returns to its owner exactly one cycle
// after the grant. A data access with d_lock=1 keeps the bus owned by the
// data port so read-modify-write sequences are not interleaved with fetches.
//
// Optional build macro: ADSD_ARB_FAIRNESS_EN
//   When defined, a wait counter lets fetch win over data after WAIT_MAX
//   consecutive denials (not while locked). When undefined, data always
//   has priority over fetch and the WAIT_MAX parameter does not exist.
//
// Ports:
//   clk, rst            : clock (rising edge), async active-low reset
//   if_req/if_addr      : fetch request and address (held until if_gnt)
//   if_gnt              : fetch granted this cycle (combinational)
//   if_rvalid/if_rdata  : fetch read data return
//   d_req/d_we/d_lock   : data request, write enable, bus lock
//   d_addr/d_wdata      : data address and write data
//   d_gnt               : data granted this cycle (combinational)
//   d_rvalid/d_rdata    : data read data return (never for writes)
//   mem_en/mem_we       : memory enable / write enable
//   mem_addr/mem_wdata  : memory address / write data
//   mem_rdata           : memory read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module adsd_mem_arbiter #(
    parameter int ADDR_W = adsd_pkg::ADDR_W,
    parameter int DATA_W = adsd_pkg::DATA_W
`ifdef ADSD_ARB_FAIRNESS_EN
    ,
    parameter int WAIT_MAX = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import adsd_pkg::*;

    logic              r_locked;
    logic              r_rdPend;
    mem_owner_t        r_rdOwner;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_dRdata;

    logic              w_ifGnt;
    logic              w_dGnt;
    logic              w_force;
    logic              w_readGnt;

`ifdef ADSD_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] r_waitCnt;

    // Fetch has been denied WAIT_MAX times in a row: let it through once.
    assign w_force = if_req && !r_locked && (r_waitCnt == CNT_W'(WAIT_MAX));

    // Count consecutive unlocked fetch denials, saturating at WAIT_MAX.
    // Cycles spent locked neither count nor reset the history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_waitCnt <= '0;
        end else if (w_ifGnt || !if_req) begin
            r_waitCnt <= '0;
        end else if (!r_locked && (r_waitCnt != CNT_W'(WAIT_MAX))) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // Single-winner grant. Grants are gated by rst so nothing reaches the
    // memory while the arbiter is held in reset.
    always_comb begin
        w_ifGnt = 1'b0;
        w_dGnt  = 1'b0;
        if (rst) begin
            if (r_locked) begin
                w_dGnt = d_req;
            end else if (w_force) begin
                w_ifGnt = 1'b1;
            end else if (d_req) begin
                w_dGnt = 1'b1;
            end else if (if_req) begin
                w_ifGnt = 1'b1;
            end
        end
    end

    assign if_gnt = w_ifGnt;
    assign d_gnt  = w_dGnt;

    // Memory port driven from the winner; idle bus is all zeros.
    always_comb begin
        mem_en    = w_ifGnt | w_dGnt;
        mem_we    = w_dGnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_dGnt) begin
            mem_addr = d_addr;
            if (d_we) begin
                mem_wdata = d_wdata;
            end
        end else if (w_ifGnt) begin
            mem_addr = if_addr;
        end
    end

    assign w_readGnt = w_ifGnt | (w_dGnt & ~d_we);

    // Remember who issued this cycle's read so the returning data goes to
    // the right port next cycle; also track the data-port bus lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdPend  <= 1'b0;
            r_rdOwner <= OWN_FETCH;
            r_locked  <= 1'b0;
        end else begin
            r_rdPend <= w_readGnt;
            if (w_readGnt) begin
                r_rdOwner <= w_dGnt ? OWN_DATA : OWN_FETCH;
            end
            if (w_dGnt) begin
                r_locked <= d_lock;
            end
        end
    end

    assign if_rvalid = r_rdPend && (r_rdOwner == OWN_FETCH);
    assign d_rvalid  = r_rdPend && (r_rdOwner == OWN_DATA);

    // Capture returning data so each port keeps showing its last word
    // while the other port owns the return path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifRdata <= '0;
            r_dRdata  <= '0;
        end else begin
            if (if_rvalid) begin
                r_ifRdata <= mem_rdata;
            end
            if (d_rvalid) begin
                r_dRdata <= mem_rdata;
            end
        end
    end

    // Data passes straight through from memory in the return cycle.
    assign if_rdata = if_rvalid ? mem_rdata : r_ifRdata;
    assign d_rdata  = d_rvalid  ? mem_rdata : r_dRdata;

endmodule : adsd_mem_arbiter

// File: doc/adsd_mem_arbiter.md
Name: adsd_mem_arbiter

Overview:
- Shares one single-port synchronous unified memory (16-bit words) between the CPU instruction-fetch port and the load/store data port.
- Sits between the datapath and the memory in the RISC top level.
- Grants at most one access per cycle and routes read data back to the owner one cycle later.
- Supports a bus lock so a load/store sequence (read-modify-write) is not interleaved with fetches.

Parameters:
- ADDR_W, 16, word address width
- DATA_W, 16, data word width
- WAIT_MAX, 4, consecutive fetch denials tolerated before fetch is forced to win (fairness build only)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_lock  in  1  keep bus locked to data port after this access
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  data read data valid (registered; never set for writes)
- d_rdata  out  DATA_W  data read data
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset (rst=0, async):
  - locked_q=0, wait_cnt=0, rd_pend_q=0, rd_owner_q=FETCH.
  - if_rvalid=d_rvalid=0; if_rdata=d_rdata=0.
  - While rst=0, if_gnt=d_gnt=mem_en=mem_we=0.
- Grant is combinational, one winner per cycle. Priority, highest first:
  - locked_q=1: only data may be granted; if_gnt=0.
  - Fairness force (optional feature only).
  - d_req.
  - if_req.
- On a grant: mem_en=1; mem_addr, mem_we and mem_wdata come from the winner (mem_we=0 for fetch). mem_wdata is 0 when not writing.
- No grant: mem_en=0, mem_we=0, mem_addr=0.
- Read latency is exactly 1 cycle:
  - A read grant in cycle N registers rd_pend_q=1 and rd_owner_q.
  - In cycle N+1 the owner's rvalid=1 and its rdata=mem_rdata, registered at the end of N+1 (visible N+2)? No: rdata is driven combinationally from mem_rdata while rvalid_q=1. The non-owner's rdata holds its previous value.
  - rvalid is a single-cycle pulse per read.
- Back-to-back reads, including alternating owners, run at full rate: each cycle may both return data and issue a new grant.
- A write grant completes in the grant cycle; no rvalid.
- Lock:
  - A data grant with d_lock=1 sets locked_q at the end of that cycle.
  - A data grant with d_lock=0 clears locked_q.
  - While locked, fetch is starved indefinitely (the CPU stalls by design).
- Simultaneous if_req and d_req with no lock and no force: data wins; fetch waits.
- Reset mid-read: the pending rvalid is dropped and no stale pulse follows reset release.
- A requester deasserting req before its grant is legal; nothing is issued for it.

Optional Feature:
- Macro: ADSD_ARB_FAIRNESS_EN.
- Defined:
  - wait_cnt increments each cycle with if_req=1, if_gnt=0 and locked_q=0, saturating at WAIT_MAX.
  - It clears on if_gnt or if_req=0.
  - When wait_cnt==WAIT_MAX and locked_q=0, fetch wins over d_req that cycle.
- Not defined: no counter; strict data-over-fetch priority.

Decomposition:
- Package adsd_pkg:
  - ADDR_W and DATA_W constants.
  - typedef enum logic {OWN_FETCH, OWN_DATA} mem_owner_t.
- A single module is sufficient; the fairness counter stays inline under the macro. No sub-module.

Test Plan:
- Reset: hold rst=0 38 ns with if_req=1 -> all gnt, rvalid and mem_en=0; after release, if_gnt=1 the first cycle and if_rvalid=1 one cycle later with the memory contents at if_addr.
- Collision: if_req=1 at 0x0004 and d_req=1 read at 0x0010 same cycle -> d_gnt first, if_gnt next cycle; d_rvalid then if_rvalid on consecutive cycles, each carrying its own address's data.
- Write: d_we=1, d_addr=0x0020, d_wdata=0xBEEF -> mem_we=1 that cycle, no d_rvalid; a later data read at 0x0020 returns 0xBEEF.
- Lock: data read at 0x0030 with d_lock=1, then write with d_lock=0, while if_req=1 throughout -> if_gnt=0 for both cycles, granted the cycle after the unlocking write.
- Fairness (macro defined, WAIT_MAX=4): d_req and if_req held continuously -> fetch granted on the 5th cycle, then data resumes; macro undefined -> fetch never granted.
- Reset mid-read: assert rst=0 in the cycle after a read grant -> no rvalid pulse during or after reset.
